// File: rtl/multi_pulse_seq_if.sv
// Config/control and pulse-output bundle for multi_pulse_seq.
// The master side configures and strobes start/stop; the slave side is the sequencer.
interface multi_pulse_seq_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 32
);
  logic           cfg_we;
  logic [7:0]     cfg_addr;
  logic [CW-1:0]  cfg_data;
  logic           start;
  logic           stop;
  logic [NCH-1:0] pulse;
  logic           sync;
  logic           busy;
  logic           done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, stop,
    input  pulse, sync, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, stop,
    output pulse, sync, busy, done
  );
endinterface

// File: rtl/multi_pulse_seq.sv
// Multi-channel periodic pulse sequencer with double-buffered config,
// optional finite burst length, and a sync marker at each period start.
module multi_pulse_seq #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CW     = 32,
  parameter int unsigned TW     = 16,
  parameter int unsigned SYNC_W = 8
) (
  input logic               clk,
  input logic               reset,
  multi_pulse_seq_if.slave  bus
);

  localparam logic [CW-1:0] MIN_PERIOD = CW'(2);
  localparam logic [CW-1:0] SYNC_LEN   = CW'(SYNC_W);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  pcnt_q, pcnt_d;

  logic [CW-1:0]  period_sh_q, period_act_q;
  logic [TW-1:0]  burst_sh_q, burst_act_q;
  logic [TW-1:0]  start_sh_q  [NCH];
  logic [TW-1:0]  stop_sh_q   [NCH];
  logic [TW-1:0]  start_act_q [NCH];
  logic [TW-1:0]  stop_act_q  [NCH];

  logic [NCH-1:0] pulse_q, pulse_d;
  logic           sync_q, sync_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           load;
  logic           wrap;
  logic           last_period;
  logic [CW-1:0]  period_eff;
  logic [CW-1:0]  sync_lim;

  assign period_eff  = (period_act_q < MIN_PERIOD) ? MIN_PERIOD : period_act_q;
  assign wrap        = (cnt_q == period_eff - CW'(1));
  assign last_period = (burst_act_q != '0) && ((pcnt_q + TW'(1)) == burst_act_q);
  assign sync_lim    = (period_eff < SYNC_LEN) ? period_eff : SYNC_LEN;

  // Next-state, counters and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    load    = 1'b0;
    done_d  = 1'b0;
    pulse_d = '0;
    sync_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = S_RUN;
          cnt_d   = '0;
          pcnt_d  = '0;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (wrap) begin
          cnt_d  = '0;
          pcnt_d = pcnt_q + TW'(1);
          load   = 1'b1;
          if (last_period) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Windows use the pre-edge state and count, so outputs lag cnt by one clock
    if (state_q == S_RUN) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        pulse_d[k] = (CW'(start_act_q[k]) <= cnt_q) && (cnt_q < CW'(stop_act_q[k]));
      end
      sync_d = (cnt_q < sync_lim);
    end

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      pulse_q <= '0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Shadow registers: written by the config port only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_sh_q <= '0;
      burst_sh_q  <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        start_sh_q[k] <= '0;
        stop_sh_q[k]  <= '0;
      end
    end else if (bus.cfg_we) begin
      if (bus.cfg_addr == 8'd0) period_sh_q <= bus.cfg_data;
      if (bus.cfg_addr == 8'd1) burst_sh_q  <= TW'(bus.cfg_data);
      for (int unsigned k = 0; k < NCH; k++) begin
        if (bus.cfg_addr == 8'(2 + 2 * k)) start_sh_q[k] <= TW'(bus.cfg_data);
        if (bus.cfg_addr == 8'(3 + 2 * k)) stop_sh_q[k]  <= TW'(bus.cfg_data);
      end
    end
  end

  // Active registers take the pre-edge shadow, so a same-edge write waits for the next load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_act_q <= '0;
      burst_act_q  <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        start_act_q[k] <= '0;
        stop_act_q[k]  <= '0;
      end
    end else if (load) begin
      period_act_q <= period_sh_q;
      burst_act_q  <= burst_sh_q;
      for (int unsigned k = 0; k < NCH; k++) begin
        start_act_q[k] <= start_sh_q[k];
        stop_act_q[k]  <= stop_sh_q[k];
      end
    end
  end

  assign bus.pulse = pulse_q;
  assign bus.sync  = sync_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
